lt24_touch_spi_master: RTL and testbench
========================================

# lt24_touch_spi_master

Avalon-MM slave SPI master for the LT24 touch controller (ADS7843-class, 12-bit, 24-clock conversion frame). Software, typically woken by the pen-IRQ PIO edge interrupt, writes an 8-bit control byte. The block runs one full conversion frame on the touch SPI pins, latches the 12-bit result and raises a maskable done interrupt. It sits in the SOPC beside the pen-IRQ input port, on the same register-map style: 2-bit word address and registered read data.

## Interface
- CLK_DIV, 25, clk cycles per SCLK half-period (≥1; 50 MHz clk → 1 MHz SCLK)
- clk  in  1  system clock
- reset_n  in  1  reset reset_n, asynchronous, active-low; clock clk
- address  in  2  register word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  done & irq_mask
- spi_cs_n  out  1  touch chip select, active low
- spi_sclk  out  1  SPI clock, idle low
- spi_mosi  out  1  control byte out, MSB first
- spi_miso  in  1  conversion data in, MSB first

## Operation
- Register map (wr = chipselect & ~write_n):
  - 0 CMD: write [7:0] = control byte; starts a frame if idle; ignored while busy. Reads 0.
  - 1 DATA: read [11:0] = last result, upper bits 0; holds until the next frame completes.
  - 2 STATUS: read bit0 busy, bit1 done. Any write clears done.
  - 3 IRQ_MASK: bit0, read/write.
- readdata is registered every cycle from the address mux and is not gated by chipselect, matching the PIO blocks.
- FSM states:
  - IDLE → SETUP on an accepted CMD write. The write sets cs_n=0, mosi=cmd[7], busy=1 and clears done.
  - SETUP: wait CLK_DIV cycles → SHIFT.
  - SHIFT: 24 SCLK periods, each CLK_DIV cycles high then CLK_DIV cycles low.
    - Rising edge k (1..24): sample miso. Edges k=10..21 shift into a 12-bit register, MSB first. Edge 9 (busy bit) and the remaining edges are discarded.
    - Falling edge k: mosi = cmd[7-k] for k=1..7, else 0.
  - SHIFT → HOLD after falling edge 24.
  - HOLD: cs_n stays low for CLK_DIV cycles → DONE.
  - DONE, one cycle: cs_n=1, DATA ← shift register, done=1, busy=0 → IDLE.
- Simultaneous events:
  - A done-set and a STATUS write in the same cycle: set wins.
  - A CMD write in the DONE cycle is ignored (still busy).
- Reset mid-frame aborts with no partial result. All state and outputs return to reset values.

## Timing
- Reset values: readdata=0, irq=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0, DATA=0, busy=0, done=0, irq_mask=0.
- Read latency: 1 cycle (readdata valid the edge after address is presented).
- CMD write sampled at edge T:
  - spi_cs_n low from T.
  - First SCLK rise at T+CLK_DIV.
  - done=1 and spi_cs_n=1 at T+50·CLK_DIV. DATA is readable on readdata one cycle after that.
- irq is combinational from registered done and irq_mask, so it follows either of them with no extra latency.
- SCLK is glitch-free and driven from a register. miso is sampled in the same clk cycle that sclk goes high.
- Minimum frame for CLK_DIV=1: 50 cycles.

## Structure
- Package lt24_touch_pkg:
  - register address constants (ADDR_CMD=0, ADDR_DATA=1, ADDR_STATUS=2, ADDR_IRQ_MASK=3)
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD, DONE)
  - SCLK_PER_FRAME=24, DATA_FIRST_EDGE=10, DATA_BITS=12
- Sub-module lt24_touch_sclk_gen:
  - CLK_DIV half-period counter; produces sclk plus one-cycle rise/fall strobes and the edge count 1..24
  - enabled only in SHIFT; counter reset on leaving SHIFT
- Top level holds the register file, FSM, MOSI/MISO shift registers and the irq logic.

## Test plan (CLK_DIV=2, SPI slave model drives miso on falling edges)
- Basic frame: write CMD=0x90, model returns 0xA5C.
  - cs_n low for 100 cycles, 24 SCLK pulses.
  - MOSI bits 1,0,0,1,0,0,0,0 then 0.
  - DATA reads 0x00000A5C; STATUS reads 0x2.
- IRQ:
  - With IRQ_MASK=1, irq asserts on the cycle done sets.
  - A STATUS write drops irq next cycle.
  - With IRQ_MASK=0, done sets but irq stays 0.
- Busy rejection: CMD=0x90 then CMD=0xD0 at cycle +10.
  - Only one frame runs, MOSI shows 0x90.
  - STATUS reads 0x1 during the frame.
- Collision: STATUS write in the same cycle done sets → done stays 1. CMD write in the DONE cycle → no new frame.
- Reset mid-frame: assert reset_n at SCLK edge 12.
  - Immediately cs_n=1, sclk=0, mosi=0, irq=0, DATA=0.
  - A following CMD runs a clean full frame.
- All-ones/all-zeros: model returns 0xFFF then 0x000 → DATA 0x00000FFF then 0x00000000; bits 31:12 always 0.

Source files
------------

// File: rtl/lt24_touch_pkg.sv
// Shared constants and types for the LT24 touch SPI master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: register word addresses, FSM state encoding, frame geometry.
package lt24_touch_pkg;

  localparam logic [1:0] ADDR_CMD      = 2'd0;
  localparam logic [1:0] ADDR_DATA     = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd3;

  // One conversion frame is 24 SCLK periods; the 12 result bits arrive on
  // rising edges 10..21 (edge 9 carries the converter's busy bit).
  localparam int SCLK_PER_FRAME  = 24;
  localparam int DATA_FIRST_EDGE = 10;
  localparam int DATA_BITS       = 12;
  localparam int DATA_LAST_EDGE  = DATA_FIRST_EDGE + DATA_BITS - 1;
  localparam int EDGE_W          = 5;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/lt24_touch_spi_master_if.sv
// Avalon-MM register bus of the touch SPI master, bundled for port lists.
// Latency: readdata is registered, valid one clk after address is presented.
// Backpressure: none; the slave never stalls, writes while busy are dropped.
//
// Signals: address[1:0], chipselect, write_n, writedata[31:0] (host -> block),
//          readdata[31:0], irq (block -> host).
interface lt24_touch_spi_master_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/lt24_touch_sclk_gen.sv
// SCLK generator: CLK_DIV-cycle half periods, rise/fall strobes, edge count.
// Latency: first rise on the start edge, each later edge CLK_DIV clks apart.
// Backpressure: none; runs while en is high, clears itself when en drops.
//
// Ports: clk, reset_n; start (launch rise 1), en (frame in SHIFT);
//        sclk (registered), rise/fall (strobes for the coming edge),
//        last (end of the low half after fall 24), edge_num (1..24).
module lt24_touch_sclk_gen
  import lt24_touch_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              en,
  output logic              sclk,
  output logic              rise,
  output logic              fall,
  output logic              last,
  output logic [EDGE_W-1:0] edge_num
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]     HALF_LAST  = CW'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] FINAL_EDGE = EDGE_W'(SCLK_PER_FRAME);

  logic [CW-1:0]     cnt;
  logic [EDGE_W-1:0] edges;   // rising edges issued so far in this frame
  logic              half_end;

  assign half_end = en && (cnt == HALF_LAST);

  // Strobes describe what the next clk edge does to sclk, so the parent can
  // sample miso in the very cycle sclk is registered high.
  assign rise     = start || (half_end && !sclk && (edges != FINAL_EDGE));
  assign fall     = half_end && sclk;
  assign last     = half_end && !sclk && (edges == FINAL_EDGE);
  assign edge_num = rise ? (edges + EDGE_W'(1)) : edges;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      sclk  <= 1'b0;
      edges <= '0;
    end else if (start) begin
      cnt   <= '0;
      sclk  <= 1'b1;
      edges <= EDGE_W'(1);
    end else if (!en) begin
      cnt   <= '0;
      sclk  <= 1'b0;
      edges <= '0;
    end else if (cnt == HALF_LAST) begin
      cnt <= '0;
      if (sclk) begin
        sclk <= 1'b0;
      end else if (edges != FINAL_EDGE) begin
        sclk  <= 1'b1;
        edges <= edges + EDGE_W'(1);
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lt24_touch_spi_master.sv
// LT24 touch SPI master: one 24-clock ADS7843 frame per CMD write, 12-bit result.
// Latency: done and cs_n high 50*CLK_DIV clks after the CMD write edge.
// Backpressure: CMD writes outside IDLE are ignored; poll STATUS.busy or irq.
//
// Ports: clk, reset_n (async, active low); bus (Avalon slave: CMD/DATA/
//        STATUS/IRQ_MASK, registered readdata, irq = done & mask);
//        spi_cs_n, spi_sclk, spi_mosi (outputs), spi_miso (input).
module lt24_touch_spi_master
  import lt24_touch_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic                          clk,
  input  logic                          reset_n,
  lt24_touch_spi_master_if.slave        bus,
  output logic                          spi_cs_n,
  output logic                          spi_sclk,
  output logic                          spi_mosi,
  input  logic                          spi_miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(CLK_DIV - 1);

  state_t                 state;
  logic [CW-1:0]          wait_cnt;
  logic [7:0]             mosi_sr;    // remaining command bits, next one in [7]
  logic [DATA_BITS-1:0]   miso_sr;
  logic [DATA_BITS-1:0]   data;
  logic                   busy;
  logic                   done;
  logic                   irq_mask;

  logic                   wr;
  logic                   wait_end;
  logic                   sclk_start;
  logic                   shift_en;
  logic                   rise;
  logic                   fall;
  logic                   last;
  logic [EDGE_W-1:0]      edge_num;
  logic                   data_edge;
  logic                   unused_wdata;

  assign wr         = bus.chipselect && !bus.write_n;
  assign wait_end   = (wait_cnt == WAIT_LAST);
  assign sclk_start = (state == SETUP) && wait_end;
  assign shift_en   = (state == SHIFT);
  assign data_edge  = (edge_num >= EDGE_W'(DATA_FIRST_EDGE)) &&
                      (edge_num <= EDGE_W'(DATA_LAST_EDGE));
  assign unused_wdata = ^bus.writedata[31:8];

  lt24_touch_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (sclk_start),
    .en       (shift_en),
    .sclk     (spi_sclk),
    .rise     (rise),
    .fall     (fall),
    .last     (last),
    .edge_num (edge_num)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mosi_sr  <= '0;
      miso_sr  <= '0;
      data     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      irq_mask <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      if (wr && (bus.address == ADDR_IRQ_MASK)) begin
        irq_mask <= bus.writedata[0];
      end
      // Cleared here; the HOLD->DONE branch below assigns later and so wins
      // when a STATUS write lands on the done-set cycle.
      if (wr && (bus.address == ADDR_STATUS)) begin
        done <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (wr && (bus.address == ADDR_CMD)) begin
            state    <= SETUP;
            wait_cnt <= '0;
            spi_cs_n <= 1'b0;
            spi_mosi <= bus.writedata[7];
            mosi_sr  <= {bus.writedata[6:0], 1'b0};
            miso_sr  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end

        SETUP: begin
          if (wait_end) begin
            state <= SHIFT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        SHIFT: begin
          if (rise && data_edge) begin
            miso_sr <= {miso_sr[DATA_BITS-2:0], spi_miso};
          end
          // After the 7 remaining command bits the zero fill keeps mosi low.
          if (fall) begin
            spi_mosi <= mosi_sr[7];
            mosi_sr  <= {mosi_sr[6:0], 1'b0};
          end
          if (last) begin
            state    <= HOLD;
            wait_cnt <= '0;
          end
        end

        HOLD: begin
          if (wait_end) begin
            state    <= DONE;
            spi_cs_n <= 1'b1;
            data     <= miso_sr;
            done     <= 1'b1;
            busy     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read mux is registered every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      case (bus.address)
        ADDR_DATA:     bus.readdata <= {{(32 - DATA_BITS){1'b0}}, data};
        ADDR_STATUS:   bus.readdata <= {30'd0, done, busy};
        ADDR_IRQ_MASK: bus.readdata <= {31'd0, irq_mask};
        default:       bus.readdata <= '0;
      endcase
    end
  end

  assign bus.irq = done & irq_mask;

endmodule

// File: tb/tb_lt24_touch_spi_master.sv
// Bench for lt24_touch_spi_master with an SPI slave model and two scoreboards:
// one for register reads, one for complete SPI frames seen on the pins.
module tb_lt24_touch_spi_master;

  localparam int CLK_DIV      = 2;
  localparam int FRAME_CYCLES = 50 * CLK_DIV;
  localparam logic [1:0] A_CMD = 2'd0, A_DATA = 2'd1, A_STATUS = 2'd2, A_MASK = 2'd3;

  logic clk = 1'b0;
  logic reset_n;
  logic spi_cs_n, spi_sclk, spi_mosi, spi_miso;

  lt24_touch_spi_master_if bus ();

  lt24_touch_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- read scoreboard ----------------
  typedef struct { logic [1:0] addr; logic [31:0] val; } rd_exp_t;
  rd_exp_t rd_q[$];
  rd_exp_t rd_cur;
  logic    rd_flag = 1'b0;
  logic    rd_seen;

  always @(posedge clk) rd_seen <= rd_flag;

  always @(negedge clk) begin
    if (rd_seen === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL read_unexpected: readdata 0x%0h with no expectation", bus.readdata);
      end else begin
        checks--;
        rd_cur = rd_q.pop_front();
        check($sformatf("read_addr%0d", rd_cur.addr), bus.readdata, rd_cur.val);
      end
    end
  end

  // ---------------- SPI slave model + frame scoreboard ----------------
  typedef struct { logic [7:0] cmd; logic irq; } fr_exp_t;
  fr_exp_t     fr_q[$];
  fr_exp_t     fr_cur;
  logic [23:0] pat_q[$];
  logic [23:0] cur_pat = '0;
  logic [23:0] mosi_cap = '0;
  int          rises = 0, falls = 0, low_cycles = 0;
  int          frames_seen = 0, frames_expected = 0;
  bit          frame_active = 1'b0;

  always @(negedge spi_cs_n) begin
    cur_pat      = (pat_q.size() > 0) ? pat_q.pop_front() : 24'h0;
    rises        = 0;
    falls        = 0;
    low_cycles   = 0;
    mosi_cap     = '0;
    frame_active = 1'b1;
    spi_miso     = cur_pat[23];
  end

  always @(posedge spi_sclk) begin
    rises++;
    mosi_cap = {mosi_cap[22:0], spi_mosi};
  end

  // Edge k+1 data is presented right after falling edge k.
  always @(negedge spi_sclk) begin
    falls++;
    if (falls < 24) spi_miso = cur_pat[23 - falls];
    else            spi_miso = 1'b0;
  end

  always @(negedge clk) if (spi_cs_n === 1'b0) low_cycles++;

  always @(posedge spi_cs_n) begin
    if (frame_active) begin
      frame_active = 1'b0;
      if (reset_n === 1'b1) begin
        frames_seen++;
        if (fr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_frame: mosi 0x%0h with no frame expected", mosi_cap);
        end else begin
          fr_cur = fr_q.pop_front();
          check("mosi_bits", {8'h0, mosi_cap}, {8'h0, fr_cur.cmd, 16'h0});
          check("sclk_rises", rises, 24);
          check("sclk_falls", falls, 24);
          check("cs_low_cycles", low_cycles, FRAME_CYCLES);
          @(negedge clk);
          check("irq_at_done", {31'd0, bus.irq}, {31'd0, fr_cur.irq});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
    rd_exp_t e;
    e.addr = a;
    e.val  = exp;
    rd_q.push_back(e);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    rd_flag        = 1'b1;
    @(negedge clk);
    rd_flag        = 1'b0;
    bus.chipselect = 1'b0;
  endtask

  // Result bits occupy edges 10..21; junk fills edges 1..9 and 22..24.
  task automatic start_frame(input logic [7:0] c, input logic [11:0] r,
                             input logic [11:0] junk, input bit irq_exp, input bit track);
    fr_exp_t e;
    pat_q.push_back({junk[11:3], r, junk[2:0]});
    if (track) begin
      e.cmd = c;
      e.irq = irq_exp;
      fr_q.push_back(e);
      frames_expected++;
    end
    bus_write(A_CMD, {24'h0, c});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (spi_cs_n !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("frame_end_in_time", {31'd0, n < 400}, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0]  c;
  logic [11:0] r;
  bit          m;

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    spi_miso       = 1'b0;
    reset_n        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    check("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    check("rst_irq",  {31'd0, bus.irq},  32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 4; a++) bus_read(2'(a), 32'h0);

    // Basic frame
    start_frame(8'h90, 12'hA5C, 12'($urandom), 1'b0, 1'b1);
    bus_read(A_STATUS, 32'h1);
    wait_idle();
    bus_read(A_DATA, 32'h0000_0A5C);
    bus_read(A_STATUS, 32'h2);
    bus_read(A_CMD, 32'h0);

    // IRQ follows mask and done
    bus_write(A_MASK, 32'h1);
    check("irq_after_mask_set", {31'd0, bus.irq}, 32'd1);
    bus_read(A_MASK, 32'h1);
    bus_write(A_STATUS, 32'h0);
    check("irq_after_status_wr", {31'd0, bus.irq}, 32'd0);
    c = 8'($urandom); r = 12'($urandom);
    start_frame(c, r, 12'($urandom), 1'b1, 1'b1);
    wait_idle();
    check("irq_held", {31'd0, bus.irq}, 32'd1);
    bus_write(A_STATUS, 32'h0);
    check("irq_drop", {31'd0, bus.irq}, 32'd0);
    bus_read(A_STATUS, 32'h0);
    bus_read(A_DATA, {20'h0, r});

    // Masked: done sets, irq stays low
    bus_write(A_MASK, 32'h0);
    c = 8'($urandom); r = 12'($urandom);
    start_frame(c, r, 12'($urandom), 1'b0, 1'b1);
    wait_idle();
    check("irq_masked", {31'd0, bus.irq}, 32'd0);
    bus_read(A_STATUS, 32'h2);

    // Busy rejection: second CMD 10 cycles in is dropped
    r = 12'($urandom);
    start_frame(8'h90, r, 12'($urandom), 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    bus_write(A_CMD, 32'hD0);
    bus_read(A_STATUS, 32'h1);
    wait_idle();
    bus_read(A_DATA, {20'h0, r});

    // STATUS write on the done-set cycle: set wins
    c = 8'($urandom); r = 12'($urandom);
    start_frame(c, r, 12'($urandom), 1'b0, 1'b1);
    repeat (FRAME_CYCLES - 1) @(negedge clk);
    bus_write(A_STATUS, 32'h0);
    bus_read(A_STATUS, 32'h2);
    wait_idle();
    bus_read(A_DATA, {20'h0, r});

    // CMD write during the DONE cycle is ignored
    c = 8'($urandom); r = 12'($urandom) | 12'h001;
    start_frame(c, r, 12'($urandom), 1'b0, 1'b1);
    repeat (FRAME_CYCLES) @(negedge clk);
    bus_write(A_CMD, {24'h0, 8'($urandom)});
    repeat (5) @(negedge clk);
    check("no_frame_from_done_cmd", {31'd0, spi_cs_n}, 32'd1);
    bus_read(A_STATUS, 32'h2);
    bus_read(A_DATA, {20'h0, r});

    // Reset in the middle of a frame
    bus_write(A_MASK, 32'h1);
    start_frame(8'($urandom), 12'($urandom), 12'($urandom), 1'b0, 1'b0);
    begin
      int n = 0;
      while (rises < 12 && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("reached_edge12", {31'd0, n < 400}, 32'd1);
    end
    reset_n = 1'b0;
    #1;
    check("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
    check("abort_sclk", {31'd0, spi_sclk}, 32'd0);
    check("abort_mosi", {31'd0, spi_mosi}, 32'd0);
    check("abort_irq",  {31'd0, bus.irq},  32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(A_DATA, 32'h0);
    bus_read(A_STATUS, 32'h0);
    bus_read(A_MASK, 32'h0);
    c = 8'($urandom); r = 12'($urandom);
    start_frame(c, r, 12'($urandom), 1'b0, 1'b1);
    wait_idle();
    bus_read(A_DATA, {20'h0, r});

    // All ones with zero junk, then all zeros with all-ones junk
    start_frame(8'($urandom), 12'hFFF, 12'h000, 1'b0, 1'b1);
    wait_idle();
    bus_read(A_DATA, 32'h0000_0FFF);
    start_frame(8'($urandom), 12'h000, 12'hFFF, 1'b0, 1'b1);
    wait_idle();
    bus_read(A_DATA, 32'h0000_0000);

    // Random frames with random mask
    for (int i = 0; i < 4; i++) begin
      m = 1'($urandom);
      bus_write(A_MASK, {31'd0, m});
      c = 8'($urandom); r = 12'($urandom);
      start_frame(c, r, 12'($urandom), m, 1'b1);
      wait_idle();
      bus_read(A_DATA, {20'h0, r});
      bus_read(A_STATUS, 32'h2);
      bus_read(A_MASK, {31'd0, m});
    end

    repeat (5) @(negedge clk);
    check("frames_seen", frames_seen, frames_expected);
    check("frame_queue_empty", fr_q.size(), 0);
    check("read_queue_empty", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
